// File: rtl/data_mem_responder_pkg.sv
// Shared address-map definitions for the data-memory responder.
// Build option: MMIO_TIMER_EN enables the timer compare register and the
// timer_hit status bit; the package itself is identical in both builds.
package mem_map_pkg;

  // Byte offsets of the MMIO registers inside the 64 KiB window
  localparam logic [15:0] OFF_CYCLE_LO  = 16'h0000;
  localparam logic [15:0] OFF_CYCLE_HI  = 16'h0004;
  localparam logic [15:0] OFF_GPIO      = 16'h0008;
  localparam logic [15:0] OFF_TIMER_CMP = 16'h000C;
  localparam logic [15:0] OFF_STATUS    = 16'h0010;

  // STATUS register layout
  localparam int STATUS_W     = 3;
  localparam int ST_TIMER_HIT = 0;
  localparam int ST_MISALIGN  = 1;
  localparam int ST_UNMAPPED  = 2;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // RAM sits at the bottom of the address space, MMIO is matched on the
  // upper half-word only, everything else falls through to unmapped.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [15:0] mmio_hi);
    region_e r;
    if (addr < ram_bytes)
      r = REG_RAM;
    else if (addr[31:16] == mmio_hi)
      r = REG_MMIO;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_mmio_regs.sv
// MMIO register block: 64-bit cycle counter with coherent high-word snapshot,
// GPIO output, timer compare and sticky W1C status flags.
// Build option: MMIO_TIMER_EN adds TIMER_CMP and the timer_hit flag; without
// it TIMER_CMP reports as an unknown offset and timer_irq is constant 0.
module mmio_regs
  import mem_map_pkg::*;
#(
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [15:0]       offset,
  input  logic [31:0]       wdata,
  input  logic              misalign_evt,
  input  logic              unmapped_evt,
  output logic [31:0]       rdata,
  output logic              offset_ok,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  logic [63:0]         cycle_cnt;
  logic [31:0]         snap_hi;
  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] w1c_mask;
  logic [STATUS_W-1:0] set_mask;
  logic                timer_hit;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_cmp;

  // Compare register is only written through its own MMIO offset
  always_ff @(posedge clk) begin
    if (!reset_n)
      timer_cmp <= '0;
    else if (wr_en && offset == OFF_TIMER_CMP)
      timer_cmp <= wdata;
  end

  assign timer_hit = (cycle_cnt[31:0] == timer_cmp) && (timer_cmp != 32'd0);
`else
  logic unused_wdata;

  assign timer_hit    = 1'b0;
  assign unused_wdata = ^wdata;
`endif

  // Free-running counter; reads elsewhere see the value before this edge
  always_ff @(posedge clk) begin
    if (!reset_n)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + 64'd1;
  end

  // Reading CYCLE_LO freezes the matching high word for a later CYCLE_HI read
  always_ff @(posedge clk) begin
    if (!reset_n)
      snap_hi <= '0;
    else if (rd_en && offset == OFF_CYCLE_LO)
      snap_hi <= cycle_cnt[63:32];
  end

  // GPIO output is driven straight from its register
  always_ff @(posedge clk) begin
    if (!reset_n)
      gpio_out <= '0;
    else if (wr_en && offset == OFF_GPIO)
      gpio_out <= wdata[GPIO_W-1:0];
  end

  assign w1c_mask = (wr_en && offset == OFF_STATUS) ? wdata[STATUS_W-1:0] : '0;
  assign set_mask = {unmapped_evt, misalign_evt, timer_hit};

  // Sticky flags: clear first, then OR in new events so a set beats a W1C
  always_ff @(posedge clk) begin
    if (!reset_n)
      status_q <= '0;
    else
      status_q <= (status_q & ~w1c_mask) | set_mask;
  end

  assign timer_irq = status_q[ST_TIMER_HIT];
  assign bus_err   = status_q[ST_MISALIGN] | status_q[ST_UNMAPPED];

  // Register read mux; offset_ok tells the top whether the offset exists
  always_comb begin
    rdata     = '0;
    offset_ok = 1'b0;
    case (offset)
      OFF_CYCLE_LO: begin
        rdata     = cycle_cnt[31:0];
        offset_ok = 1'b1;
      end
      OFF_CYCLE_HI: begin
        rdata     = snap_hi;
        offset_ok = 1'b1;
      end
      OFF_GPIO: begin
        rdata[GPIO_W-1:0] = gpio_out;
        offset_ok         = 1'b1;
      end
`ifdef MMIO_TIMER_EN
      OFF_TIMER_CMP: begin
        rdata     = timer_cmp;
        offset_ok = 1'b1;
      end
`endif
      OFF_STATUS: begin
        rdata[STATUS_W-1:0] = status_q;
        offset_ok           = 1'b1;
      end
      default: begin
        rdata     = '0;
        offset_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Zero-wait-state data-memory responder for the single-cycle core: word RAM,
// address decode and the read mux. MMIO registers live in mmio_regs.
// Build option: MMIO_TIMER_EN (see mmio_regs) enables the timer feature.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          DATA_MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
  parameter int          GPIO_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_writedata,
  output logic [31:0]       mem_readdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int          AW        = $clog2(DATA_MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DATA_MEM_WORDS * 4);

  logic [31:0]   ram [DATA_MEM_WORDS];
  region_e       region;
  logic          access;
  logic          misaligned;
  logic          ram_sel;
  logic          mmio_sel;
  logic [AW-1:0] word_idx;
  logic [31:0]   mmio_rdata;
  logic          mmio_offset_ok;
  logic          misalign_evt;
  logic          unmapped_evt;

  assign region     = decode_region(mem_addr, RAM_BYTES, MMIO_BASE[31:16]);
  assign access     = memread | memwrite;
  assign misaligned = (mem_addr[1:0] != 2'b00);
  assign ram_sel    = (region == REG_RAM)  && !misaligned;
  assign mmio_sel   = (region == REG_MMIO) && !misaligned;
  assign word_idx   = mem_addr[AW+1:2];

  assign misalign_evt = access && misaligned;
  assign unmapped_evt = access && !misaligned &&
                        ((region == REG_NONE) ||
                         (region == REG_MMIO && !mmio_offset_ok));

  // RAM write port; a write presented while reset is low is dropped
  always_ff @(posedge clk) begin
    if (reset_n && memwrite && ram_sel)
      ram[word_idx] <= mem_writedata;
  end

  // Read data is purely combinational so the core sees it in the same cycle
  always_comb begin
    mem_readdata = '0;
    if (memread) begin
      if (ram_sel)
        mem_readdata = ram[word_idx];
      else if (mmio_sel && mmio_offset_ok)
        mem_readdata = mmio_rdata;
    end
  end

  mmio_regs #(
    .GPIO_W (GPIO_W)
  ) u_regs (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_en        (memread & mmio_sel),
    .wr_en        (memwrite & mmio_sel),
    .offset       (mem_addr[15:0]),
    .wdata        (mem_writedata),
    .misalign_evt (misalign_evt),
    .unmapped_evt (unmapped_evt),
    .rdata        (mmio_rdata),
    .offset_ok    (mmio_offset_ok),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq),
    .bus_err      (bus_err)
  );

endmodule
